// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate formats and the decoded packet.
package rv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    // Widest supported XLEN; narrower stages keep the low bits.
    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
    } imm_pkt_t;

    function automatic logic [IMM_MAX_W-1:0] sext_max(input logic signed [31:0] v);
        return IMM_MAX_W'(v);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: classifies the format of one instruction and
// produces its immediate sign-extended to the widest supported XLEN.
module imm_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output imm_pkt_t    pkt
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        pkt.instr   = instr;
        pkt.imm     = '0;
        pkt.fmt     = FMT_NONE;
        pkt.illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                // Shifts carry funct7 in the upper immediate bits, so only the shamt field is kept.
                if (is_shift) begin
                    pkt.fmt = FMT_SHAMT;
                    pkt.imm = RV64 ? IMM_MAX_W'(instr[25:20]) : IMM_MAX_W'(instr[24:20]);
                end else begin
                    pkt.fmt = FMT_I;
                    pkt.imm = sext_max(imm_i);
                end
            end
            OP_IMM_32: begin
                if (!RV64) begin
                    pkt.illegal = 1'b1;
                end else if (is_shift) begin
                    pkt.fmt = FMT_SHAMT;
                    pkt.imm = IMM_MAX_W'(instr[24:20]);
                end else if (funct3 == 3'b000) begin
                    pkt.fmt = FMT_I;
                    pkt.imm = sext_max(imm_i);
                end else begin
                    pkt.illegal = 1'b1;
                end
            end
            LOAD, JALR, SYSTEM: begin
                pkt.fmt = FMT_I;
                pkt.imm = sext_max(imm_i);
            end
            STORE: begin
                pkt.fmt = FMT_S;
                pkt.imm = sext_max(imm_s);
            end
            BRANCH: begin
                pkt.fmt = FMT_B;
                pkt.imm = sext_max(imm_b);
            end
            LUI, AUIPC: begin
                pkt.fmt = FMT_U;
                pkt.imm = sext_max(imm_u);
            end
            JAL: begin
                pkt.fmt = FMT_J;
                pkt.imm = sext_max(imm_j);
            end
            OP, MISC_MEM: begin
                pkt.fmt = FMT_NONE;
            end
            OP_32: begin
                pkt.illegal = !RV64;
            end
            default: begin
                pkt.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decode stage: one-cycle registered decode behind a valid/ready
// handshake, with an optional skid entry so in_ready does not depend on out_ready.
module imm_decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    imm_pkt_t dec_p0;
    imm_pkt_t main_p1;
    imm_pkt_t skid_p1;
    logic     vld_main_p1;
    logic     vld_skid_p1;
    logic     in_fire;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .pkt   (dec_p0)
    );

    generate
        if (SKID) begin : g_skid_ready
            assign in_ready = !vld_skid_p1;
        end else begin : g_direct_ready
            assign in_ready = !vld_main_p1 || out_ready;
        end
    endgenerate

    assign in_fire = in_valid && in_ready;

    // p0 -> p1: decode result lands in main, or in skid while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
            main_p1     <= '0;
            skid_p1     <= '0;
        end else if (flush) begin
            vld_main_p1 <= 1'b0;
            vld_skid_p1 <= 1'b0;
        end else if (!vld_main_p1 || out_ready) begin
            // in_ready is low while skid holds data, so no new input competes with the refill.
            if (vld_skid_p1) begin
                main_p1     <= skid_p1;
                vld_main_p1 <= 1'b1;
                vld_skid_p1 <= 1'b0;
            end else begin
                vld_main_p1 <= in_fire;
                if (in_fire) begin
                    main_p1 <= dec_p0;
                end
            end
        end else if (in_fire && SKID) begin
            skid_p1     <= dec_p0;
            vld_skid_p1 <= 1'b1;
        end
    end

    assign out_valid   = vld_main_p1;
    assign out_instr   = main_p1.instr;
    assign out_imm     = main_p1.imm[XLEN-1:0];
    assign out_fmt     = main_p1.fmt;
    assign out_illegal = main_p1.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed RV32/RV64 decodes, skid ordering, flush, async
// reset and a randomized stream compared against an arithmetic reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        in_valid_w = 1'b0;
    logic        in_ready_w;
    logic [31:0] in_instr_w = '0;
    logic        out_valid_w;
    logic [31:0] out_instr_w;
    logic [63:0] out_imm_w;
    logic [2:0]  out_fmt_w;
    logic        out_illegal_w;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic [6:0] op_pool [16] = '{7'h13, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h1B, 7'h3B, 7'h7F, 7'h00};

    imm_decode_stage #(.XLEN(32), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64), .SKID(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w),
        .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w),
        .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_illegal(out_illegal_w)
    );

    always #5 clk = ~clk;

    // Reference: immediates as signed integers assembled from their bit fields.
    function automatic exp_t model(input logic [31:0] ins, input bit rv64);
        exp_t        e;
        longint      v;
        logic [2:0]  f3;
        bit          shift;
        f3    = ins[14:12];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e.instr = ins;
        e.fmt   = 3'd0;
        e.ill   = 1'b0;
        v       = 0;
        case (ins[6:0])
            7'h13: begin
                if (shift) begin
                    e.fmt = 3'd6;
                    v = rv64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    e.fmt = 3'd1;
                    v = longint'(ins[31:20]);
                    if (v >= 2048) v -= 4096;
                end
            end
            7'h1B: begin
                if (!rv64) e.ill = 1'b1;
                else if (shift) begin
                    e.fmt = 3'd6;
                    v = longint'(ins[24:20]);
                end else if (f3 == 3'd0) begin
                    e.fmt = 3'd1;
                    v = longint'(ins[31:20]);
                    if (v >= 2048) v -= 4096;
                end else e.ill = 1'b1;
            end
            7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1;
                v = longint'(ins[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v -= 64'sh1_0000_0000;
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h33, 7'h0F: e.fmt = 3'd0;
            7'h3B: e.ill = !rv64;
            default: e.ill = 1'b1;
        endcase
        e.imm = rv64 ? 64'(v) : {32'd0, 32'(v)};
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r      = $urandom;
        r[6:0] = op_pool[$urandom_range(0, 15)];
        return r;
    endfunction

    task automatic test_reset();
        #3;
        total += 6;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (out_imm !== 32'd0) begin bad++; $display("FAIL reset_out_imm got=%h want=0", out_imm); end
        if (out_fmt !== 3'd0) begin bad++; $display("FAIL reset_out_fmt got=%0d want=0", out_fmt); end
        if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_out_illegal got=%b want=0", out_illegal); end
        if (out_instr !== 32'd0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_decode32();
        logic [31:0] ins_t [12] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                                    32'h0010006F, 32'h4030D093, 32'h0000007F, 32'h0000009B,
                                    32'h002081B3, 32'h00109093, 32'hFFC12083, 32'h00000010};
        logic [31:0] imm_t [12] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                    32'h00000800, 32'h00000003, 32'h0, 32'h0,
                                    32'h0, 32'h00000001, 32'hFFFFFFFC, 32'h0};
        logic [2:0]  fmt_t [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0,
                                    3'd0, 3'd6, 3'd1, 3'd0};
        logic        ill_t [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_instr  = ins_t[i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            total += 5;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL dec32_valid[%0d] got=%b want=1", i, out_valid); end
            if (out_imm !== imm_t[i]) begin bad++; $display("FAIL dec32_imm[%0d] got=%h want=%h", i, out_imm, imm_t[i]); end
            if (out_fmt !== fmt_t[i]) begin bad++; $display("FAIL dec32_fmt[%0d] got=%0d want=%0d", i, out_fmt, fmt_t[i]); end
            if (out_illegal !== ill_t[i]) begin bad++; $display("FAIL dec32_illegal[%0d] got=%b want=%b", i, out_illegal, ill_t[i]); end
            if (out_instr !== ins_t[i]) begin bad++; $display("FAIL dec32_instr[%0d] got=%h want=%h", i, out_instr, ins_t[i]); end
        end
    endtask

    task automatic test_decode64();
        logic [31:0] ins_t [6] = '{32'h800000B7, 32'h03F09093, 32'hFFF0809B, 32'h0010909B,
                                   32'h0020803B, 32'h0000009B};
        logic [63:0] imm_t [6] = '{64'hFFFFFFFF80000000, 64'd63, 64'hFFFFFFFFFFFFFFFF, 64'd1,
                                   64'd0, 64'd0};
        logic [2:0]  fmt_t [6] = '{3'd4, 3'd6, 3'd1, 3'd6, 3'd0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid_w = 1'b1;
            in_instr_w = ins_t[i];
            @(posedge clk); #1;
            in_valid_w = 1'b0;
            total += 4;
            if (out_valid_w !== 1'b1) begin bad++; $display("FAIL dec64_valid[%0d] got=%b want=1", i, out_valid_w); end
            if (out_imm_w !== imm_t[i]) begin bad++; $display("FAIL dec64_imm[%0d] got=%h want=%h", i, out_imm_w, imm_t[i]); end
            if (out_fmt_w !== fmt_t[i]) begin bad++; $display("FAIL dec64_fmt[%0d] got=%0d want=%0d", i, out_fmt_w, fmt_t[i]); end
            if (out_illegal_w !== 1'b0) begin bad++; $display("FAIL dec64_illegal[%0d] got=%b want=0", i, out_illegal_w); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a = 32'h00100093;
        logic [31:0] b = 32'h00200113;
        logic [31:0] c = 32'h00300193;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = a;
        @(posedge clk); #1;
        in_instr = b;
        @(posedge clk); #1;
        in_instr = c;
        total += 3;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full got=%b want=0", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", out_valid); end
        if (out_instr !== a) begin bad++; $display("FAIL b2b_head got=%h want=%h", out_instr, a); end
        repeat (2) @(posedge clk);
        #1;
        total += 2;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_hold got=%b want=0", in_ready); end
        if (out_instr !== a) begin bad++; $display("FAIL b2b_head_stable got=%h want=%h", out_instr, a); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total += 2;
        if (out_instr !== b) begin bad++; $display("FAIL b2b_second got=%h want=%h", out_instr, b); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_free got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total += 2;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_third_valid got=%b want=1", out_valid); end
        if (out_instr !== c) begin bad++; $display("FAIL b2b_third got=%h want=%h", out_instr, c); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00500293;
        @(posedge clk); #1;
        in_instr = 32'h00600313;
        @(posedge clk); #1;
        in_instr = 32'h00700393;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d] got=%b want=0 instr=%h", i, out_valid, out_instr); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d = 32'hABC00513;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        @(posedge clk); #1;
        in_instr = 32'h00200113;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
        if (out_instr !== 32'd0) begin bad++; $display("FAIL arst_instr got=%h want=0", out_instr); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_first_valid got=%b want=1", out_valid); end
        if (out_instr !== d) begin bad++; $display("FAIL arst_first_instr got=%h want=%h", out_instr, d); end
        if (out_imm !== 32'hFFFFFABC) begin bad++; $display("FAIL arst_first_imm got=%h want=FFFFFABC", out_imm); end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_no_stale got=%b want=0", out_valid); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        for (int cyc = 0; cyc < 3008; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_instr  = gen_instr();
                out_ready = ($urandom_range(0, 2) != 0);
                flush     = ($urandom_range(0, 63) == 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                flush     = 1'b0;
            end
            @(negedge clk);
            total += 2;
            if (out_valid !== (q.size() > 0)) begin
                bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, q.size() > 0);
            end
            if (in_ready !== (q.size() < 2)) begin
                bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, q.size() < 2);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    total++;
                    if (out_instr !== e.instr || out_imm !== e.imm[31:0] ||
                        out_fmt !== e.fmt || out_illegal !== e.ill) begin
                        bad++;
                        $display("FAIL rnd_data cyc=%0d got=%h/%h/%0d/%b want=%h/%h/%0d/%b", cyc,
                                 out_instr, out_imm, out_fmt, out_illegal,
                                 e.instr, e.imm[31:0], e.fmt, e.ill);
                    end
                end
                if (in_valid && in_ready) q.push_back(model(in_instr, 1'b0));
            end
        end
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_decode32();
        test_decode64();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
